// File: rtl/poly_cmd_pkg.sv
// rtl/poly_cmd_pkg.sv - shared opcodes, command field layout, error codes and FSM states
//
// Purpose: single source of truth for the polynomial command word format,
//          shared by the command encoder and the command decoder.
// Contents: opcode constants, command field bit positions, error codes,
//           encoder state encoding, payload counter width, pack_cmd() helper.
package poly_cmd_pkg;

  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_RST = 8'd3;

  localparam int CMD_W         = 16;
  localparam int CMD_INSTR_LSB = 8;
  localparam int CMD_ARG1_LSB  = 5;
  localparam int CMD_ARG2_LSB  = 0;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_ARG    = 2'b10;

  // arg2 + 1 can reach 32, so the payload counter needs one bit more than arg2.
  localparam int              CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_WRITE_CMD  = 3'd2,
    ST_WRITE_DATA = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERROR      = 3'd5
  } state_e;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [7:0] instr,
                                                input logic [2:0] arg1,
                                                input logic [4:0] arg2);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_INSTR_LSB +: 8] = instr;
    w[CMD_ARG1_LSB  +: 3] = arg1;
    w[CMD_ARG2_LSB  +: 5] = arg2;
    return w;
  endfunction

endpackage

// File: rtl/poly_payload_counter.sv
// rtl/poly_payload_counter.sv - loadable payload word down-counter with zero flag
//
// Purpose: counts the payload words still owed for the current command.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, clears the count
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  payload count to load
//   dec_i       decrement by one (saturates at zero)
//   count_o     current count
//   zero_o      count is zero
module poly_payload_counter
  import poly_cmd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/poly_cmd_encoder_fsm.sv
// rtl/poly_cmd_encoder_fsm.sv - validates a polynomial command and writes it plus payload to FIFOs
//
// Purpose: on start, latch {instr, arg1, arg2}, validate it, write the packed
//          command word to the command FIFO, then stream the payload words
//          from data_in to the data FIFO, and pulse done (with error code).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, instr, arg1, arg2 command request (sampled in IDLE only)
//   data_in, data_valid      payload word source; data_ready = accepted
//   command_fifo_full        command FIFO back-pressure
//   data_fifo_full           data FIFO back-pressure
//   wr_out_command, command_out  command FIFO write port
//   wr_out_data, data_out        data FIFO write port
//   busy, done, error        status
//   cmd_count                completed-command counter (POLY_CMD_ENC_STATS_EN only)
// Build option: POLY_CMD_ENC_STATS_EN adds the cmd_count output.
module poly_cmd_encoder_fsm
  import poly_cmd_pkg::*;
#(
  parameter int word_size  = 16,
  parameter int max_degree = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           instr,
  input  logic [2:0]           arg1,
  input  logic [4:0]           arg2,
  input  logic [word_size-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 command_fifo_full,
  input  logic                 data_fifo_full,
  output logic                 wr_out_command,
  output logic [word_size-1:0] command_out,
  output logic                 wr_out_data,
  output logic [word_size-1:0] data_out,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           error
`ifdef POLY_CMD_ENC_STATS_EN
  ,
  output logic [15:0]          cmd_count
`endif
);

  state_e     state_q, state_d;
  logic [7:0] instr_q;
  logic [2:0] arg1_q;
  logic [4:0] arg2_q;
  logic [1:0] err_q, err_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_value;

  poly_payload_counter u_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  // Validation of the latched fields; only consumed in CHECK.
  always_comb begin
    err_d = ERR_OK;
    if (instr_q > OP_RST) begin
      err_d = ERR_OPCODE;
    end else if (((instr_q == OP_STP) && (32'(arg2_q) > max_degree)) ||
                 ((instr_q == OP_EVB) && (arg2_q == '0))) begin
      err_d = ERR_ARG;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_dec        = 1'b0;
    wr_out_command = 1'b0;
    command_out    = '0;
    data_ready     = 1'b0;
    wr_out_data    = 1'b0;
    data_out       = '0;
    done           = 1'b0;
    error          = ERR_OK;
    busy           = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (err_d != ERR_OK) begin
          state_d = ST_ERROR;
        end else begin
          cnt_load = 1'b1;
          unique case (instr_q)
            OP_STP:  cnt_load_val = CNT_W'(arg2_q) + CNT_ONE;
            OP_EVP:  cnt_load_val = CNT_ONE;
            OP_EVB:  cnt_load_val = CNT_W'(arg2_q);
            default: cnt_load_val = '0;
          endcase
          state_d = ST_WRITE_CMD;
        end
      end
      ST_WRITE_CMD: begin
        command_out[CMD_W-1:0] = pack_cmd(instr_q, arg1_q, arg2_q);
        wr_out_command         = !command_fifo_full;
        if (wr_out_command) state_d = cnt_zero ? ST_DONE : ST_WRITE_DATA;
      end
      ST_WRITE_DATA: begin
        data_ready  = !data_fifo_full;
        data_out    = data_in;
        wr_out_data = data_valid && data_ready;
        if (wr_out_data) begin
          cnt_dec = 1'b1;
          // The write that consumes the last owed word finishes the command.
          if (cnt_value == CNT_ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        done    = 1'b1;
        error   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      arg1_q  <= '0;
      arg2_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        instr_q <= instr;
        arg1_q  <= arg1;
        arg2_q  <= arg2;
      end
      if (state_q == ST_CHECK) err_q <= err_d;
    end
  end

`ifdef POLY_CMD_ENC_STATS_EN
  logic [15:0] cmd_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_count_q <= '0;
    end else if (state_q == ST_DONE) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign cmd_count = cmd_count_q;
`endif

endmodule

// File: doc/poly_cmd_encoder_fsm.md
POLY_CMD_ENCODER_FSM -- requirements
Module: poly_cmd_encoder_fsm

Interface
REQ-001 SHALL have parameter word_size, default 16, width of command and data words.
REQ-002 SHALL have parameter max_degree, default 10, largest legal STP degree (arg2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to issue one command; sampled only in IDLE.
REQ-006 SHALL have port instr  input  8  opcode: STP=0, EVP=1, EVB=2, RST=3.
REQ-007 SHALL have port arg1  input  3  polynomial slot 0..7.
REQ-008 SHALL have port arg2  input  5  STP degree, or EVB sample count.
REQ-009 SHALL have port data_in  input  word_size  payload word (coefficient or x value).
REQ-010 SHALL have port data_valid  input  1  data_in is valid.
REQ-011 SHALL have port data_ready  output  1  payload word accepted this cycle when data_valid is high.
REQ-012 SHALL have port command_fifo_full  input  1  command FIFO cannot accept a word.
REQ-013 SHALL have port data_fifo_full  input  1  data FIFO cannot accept a word.
REQ-014 SHALL have port wr_out_command  output  1  command FIFO write strobe.
REQ-015 SHALL have port command_out  output  word_size  packed command word.
REQ-016 SHALL have port wr_out_data  output  1  data FIFO write strobe.
REQ-017 SHALL have port data_out  output  word_size  payload word to the data FIFO.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse when a command completes or is rejected.
REQ-020 SHALL have port error  output  2  00 ok, 01 bad opcode, 10 bad argument; valid while done is high.

Function
REQ-021 SHALL pack command_out as {instr, arg1, arg2} in bits [15:8], [7:5], [4:0].
REQ-022 SHALL sequence through the states IDLE -> CHECK -> WRITE_CMD -> WRITE_DATA -> DONE, with CHECK -> ERROR -> IDLE on a validation failure.
REQ-023 SHALL, in IDLE with start=1, latch instr, arg1 and arg2 and move to CHECK; start in any other state SHALL be ignored.
REQ-024 SHALL, in CHECK, load the payload count as follows: STP = arg2+1, EVP = 1, EVB = arg2, RST = 0.
REQ-025 SHALL report error=01 for an opcode greater than 3.
REQ-026 SHALL report error=10 for STP with arg2 > max_degree, or for EVB with arg2 = 0.
REQ-027 SHALL, in WRITE_CMD, assert wr_out_command = !command_fifo_full, and advance only on the cycle that write occurs.
REQ-028 SHALL, when the payload count is 0 after the command write, go directly to DONE.
REQ-029 SHALL, in WRITE_DATA, drive data_ready = !data_fifo_full, wr_out_data = data_valid & data_ready, and data_out = data_in combinationally.
REQ-030 SHALL decrement the payload count on each write, and enter DONE on the write that takes the count to 0.
REQ-031 SHALL hold state with no FIFO writes while a full flag is high, with no timeout.
REQ-032 SHALL, in DONE, assert done for one cycle with error=00 and then return to IDLE.
REQ-033 SHALL, in ERROR, assert done for one cycle with the error code, perform no FIFO writes, and then return to IDLE.
REQ-034 SHALL, with no stalls and start accepted at cycle 0, write the command at cycle 2, write payload words from cycle 3, and assert done the cycle after the last write.
REQ-035 SHALL keep wr_out_command, wr_out_data and data_ready low outside their own states.

Reset
REQ-036 SHALL, when rst is low, asynchronously force IDLE and clear all outputs, latched fields and counters to 0.
REQ-037 SHALL, on reset mid-command, abandon the command, with no further strobes and no done pulse.

Configuration
REQ-038 SHALL, with POLY_CMD_ENC_STATS_EN defined, add output cmd_count (16 bits): it increments on each DONE, does not increment on ERROR, wraps from 0xFFFF to 0, and clears on reset.
REQ-039 SHALL, without POLY_CMD_ENC_STATS_EN, omit the cmd_count port and its counter, with all other behaviour identical.

Structure
REQ-040 SHALL take the opcodes, field bit positions, error codes and state encodings from shared package poly_cmd_pkg, which the command decoder also uses.
REQ-041 SHALL implement the payload down-counter as sub-module poly_payload_counter (load, decrement, zero flag).

Verification
REQ-042 SHALL cover: STP slot 2, degree 3, no stalls -> command_out 0x0043 at cycle 2, four data writes at cycles 3-6, done at cycle 7 with error 00.
REQ-043 SHALL cover: EVB slot 1, arg2=4, with data_fifo_full high for 3 cycles mid-burst -> exactly 4 data writes and no strobe while full.
REQ-044 SHALL cover: instr=7 -> done with error 01 and zero FIFO writes.
REQ-045 SHALL cover: STP with arg2=11, and EVB with arg2=0 -> each gives done with error 10 and zero writes.
REQ-046 SHALL cover: RST slot 5 while command_fifo_full is high for 2 cycles -> a single command write of 0x03A0, followed by done.
REQ-047 SHALL cover: rst asserted after the second EVB payload word -> IDLE at once with outputs 0, and no done pulse.
